// File: rtl/stream_upsizer_if.sv
// Handshake bundle for stream_upsizer: narrow input stream (_s)
// and packed wide output stream (_m) with lane keep and last.
interface stream_upsizer_if #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
);
    logic                    valid_s;
    logic [DATA_W-1:0]       data_s;
    logic                    last_s;
    logic                    ready_s;
    logic                    valid_m;
    logic [DATA_W*RATIO-1:0] data_m;
    logic [RATIO-1:0]        keep_m;
    logic                    last_m;
    logic                    ready_m;

    // Upsizer side: consumes the narrow stream, produces wide words.
    modport slave (
        input  valid_s, data_s, last_s, ready_m,
        output ready_s, valid_m, data_m, keep_m, last_m
    );

    // Environment side: feeds narrow beats, sinks wide words.
    modport master (
        output valid_s, data_s, last_s, ready_m,
        input  ready_s, valid_m, data_m, keep_m, last_m
    );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow valid/ready beats into one wide word, little-endian.
// A last beat flushes a partial word; keep_m marks the filled lanes.
module stream_upsizer #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_upsizer_if.slave   bus
);
    localparam int CW = $clog2(RATIO);
    localparam int WW = DATA_W * RATIO;

    if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
        $error("stream_upsizer: RATIO must be in 2..16");
    end

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    acc_q, acc_d;
    logic [RATIO-1:0] kacc_q, kacc_d;
    logic [WW-1:0]    data_q, data_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;

    logic             ready;
    logic             take;
    logic             done;
    logic [WW-1:0]    merged;
    logic [RATIO-1:0] kmerged;

    // Handshake, lane merge of the incoming beat and next-state selection.
    always_comb begin
        ready   = !valid_q || bus.ready_m;
        take    = bus.valid_s && ready;
        done    = (cnt_q == CW'(RATIO - 1)) || bus.last_s;

        merged  = acc_q;
        merged[cnt_q*DATA_W +: DATA_W] = bus.data_s;
        kmerged = kacc_q | (RATIO'(1) << cnt_q);

        cnt_d   = cnt_q;
        acc_d   = acc_q;
        kacc_d  = kacc_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q && !bus.ready_m;

        if (take) begin
            if (done) begin
                // Lanes above cnt are still zero in the accumulator.
                data_d  = merged;
                keep_d  = kmerged;
                last_d  = bus.last_s;
                valid_d = 1'b1;
                acc_d   = '0;
                kacc_d  = '0;
                cnt_d   = '0;
            end else begin
                acc_d   = merged;
                kacc_d  = kmerged;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // Accumulator, slot counter and output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            kacc_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            kacc_q  <= kacc_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_s = ready;
    assign bus.valid_m = valid_q;
    assign bus.data_m  = data_q;
    assign bus.keep_m  = keep_q;
    assign bus.last_m  = last_q;
endmodule
